gpmc_master_engine: RTL and testbench

//  Parametrised, synthesisable GPMC asynchronous master that turns commands into EM_* pin cycles.

---
 rtl/gpmc_master_engine.sv | 153 +++++++++++++++
 tb/tb_gpmc_master_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_master_engine.sv
// gpmc_master_engine: parametrised GPMC async master turning command bursts into EM_* pin cycles.
// Define GPMC_WAIT_EN to honour EM_WAIT0 with a WAIT_MAX stretch timeout.
module gpmc_master_engine #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 10,
  parameter int NUM_CS   = 2,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1,
  parameter int T_TURN   = 2,
  parameter int WAIT_MAX = 255,
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [CSW-1:0]      cmd_cs,
  input  logic [AWIDTH-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                timeout_err,
  output logic [AWIDTH-1:0]   EM_A,
  output logic [DWIDTH-1:0]   EM_D_o,
  output logic                EM_D_oe,
  input  logic [DWIDTH-1:0]   EM_D_i,
  output logic [DWIDTH/8-1:0] EM_NBE,
  output logic [NUM_CS-1:0]   EM_NCS,
  output logic                EM_NWE,
  output logic                EM_NOE,
  input  logic                EM_WAIT0
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, STROBE, HOLD, TURN} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [CSW-1:0] cs, cs_n;
  logic [8:0] beats;
  logic wr, wr_n, accept, cnt_done, strobe_exit, active_n, last_beat;
  logic [NUM_CS-1:0] ncs_n;
  assign accept    = cmd_valid & cmd_ready;
  assign cnt_done  = cnt == '0;
  assign last_beat = beats == '0;
  assign EM_NBE    = '0;
  assign cs_n      = accept ? cmd_cs : cs;
  assign wr_n      = accept ? cmd_write : wr;
  assign active_n  = state_n == SETUP || state_n == STROBE || state_n == HOLD;
`ifdef GPMC_WAIT_EN
  localparam int WW = $clog2(WAIT_MAX + 2);
  logic [WW-1:0] stretch;
  logic tout, timeout_hit;
  assign timeout_hit = cnt_done & EM_WAIT0 & (stretch == WW'(WAIT_MAX));
  assign strobe_exit = cnt_done & (~EM_WAIT0 | timeout_hit);
  assign timeout_err = tout;
  always_ff @(posedge clk)
    if (reset) begin
      stretch <= '0;
      tout    <= 1'b0;
    end else begin
      stretch <= state != STROBE ? '0 : (cnt_done && !strobe_exit) ? stretch + WW'(1) : stretch;
      tout    <= tout | (state == STROBE && timeout_hit);
    end
`else
  logic unused_wait;
  assign unused_wait = EM_WAIT0 ^ (WAIT_MAX == 0);
  assign strobe_exit = cnt_done;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt_done ? cnt : cnt - 16'd1;
    case (state)
      IDLE:
        if (accept) begin
          state_n = cmd_write ? WDATA : SETUP;
          cnt_n   = 16'(T_SETUP - 1);
        end
      WDATA:
        if (wr_valid) begin
          state_n = SETUP;
          cnt_n   = 16'(T_SETUP - 1);
        end
      SETUP:
        if (cnt_done) begin
          state_n = STROBE;
          cnt_n   = 16'(T_STROBE - 1);
        end
      STROBE:
        if (strobe_exit) begin
          state_n = HOLD;
          cnt_n   = 16'(T_HOLD - 1);
        end
      HOLD:
        if (cnt_done) begin
          state_n = !last_beat ? (wr ? WDATA : SETUP) : (!wr && T_TURN > 0) ? TURN : IDLE;
          cnt_n   = !last_beat ? 16'(T_SETUP - 1) : 16'(T_TURN - 1);
        end
      TURN:
        if (cnt_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ncs_n = '1;
    for (int i = 0; i < NUM_CS; i++) ncs_n[i] = !(active_n && cs_n == CSW'(i));
  end
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cs        <= '0;
      wr        <= 1'b0;
      beats     <= '0;
      EM_A      <= '0;
      EM_D_o    <= '0;
      EM_D_oe   <= 1'b0;
      EM_NCS    <= '1;
      EM_NWE    <= 1'b1;
      EM_NOE    <= 1'b1;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cs    <= cs_n;
      wr    <= wr_n;
      if (accept) begin
        EM_A  <= cmd_addr;
        beats <= {1'b0, cmd_len};
      end else if (state == HOLD && cnt_done && !last_beat) begin
        EM_A  <= EM_A + AWIDTH'(1);
        beats <= beats - 9'd1;
      end
      if (state == WDATA && wr_valid) EM_D_o <= wr_data;
      if (state == STROBE && strobe_exit && !wr) rd_data <= EM_D_i;
      rd_valid  <= state == STROBE && strobe_exit && !wr;
      EM_NCS    <= ncs_n;
      EM_NWE    <= !(state_n == STROBE && wr_n);
      EM_NOE    <= !(state_n == STROBE && !wr_n);
      EM_D_oe   <= wr_n && active_n;
      cmd_ready <= state_n == IDLE;
      wr_ready  <= state_n == WDATA;
      busy      <= state_n != IDLE;
    end
endmodule

// File: tb/tb_gpmc_master_engine.sv
// tb_gpmc_master_engine: directed checks of burst timing, wrap, stalls, wait/timeout and reset.
module tb_gpmc_master_engine;
`ifdef GPMC_WAIT_EN
  localparam int WMAX = 8;
`else
  localparam int WMAX = 255;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [0:0] cmd_cs = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [15:0] wr_data = '0, rd_data, EM_D_o, EM_D_i;
  logic wr_valid = 1'b1, wr_ready, rd_valid, busy, timeout_err;
  logic [9:0] EM_A;
  logic EM_D_oe, EM_NWE, EM_NOE, EM_WAIT0 = 1'b0;
  logic [1:0] EM_NBE, EM_NCS;
  logic [15:0] mem [0:1023];
  int nvec = 0, nfail = 0, cyc = 0;
  int npulse, nrd, busy_cyc, widx, nstall, stall_bad, stall_left, stall_beat, wait_mode, last_rd;
  int plen [16], pstart [16];
  logic [9:0] paddr [16];
  logic [15:0] pdata [16], rdv [16], wbase;
  logic [1:0] pncs [16];
  logic cons, prev_low, low;

  gpmc_master_engine #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_cs(cmd_cs), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .timeout_err(timeout_err), .EM_A(EM_A),
    .EM_D_o(EM_D_o), .EM_D_oe(EM_D_oe), .EM_D_i(EM_D_i), .EM_NBE(EM_NBE),
    .EM_NCS(EM_NCS), .EM_NWE(EM_NWE), .EM_NOE(EM_NOE), .EM_WAIT0(EM_WAIT0)
  );

  always #5 clk = ~clk;
  assign EM_D_i = !EM_NOE ? mem[EM_A] : 16'h0000;

  task automatic clr(input logic [15:0] base);
    npulse = 0; nrd = 0; busy_cyc = 0; widx = 0; nstall = 0; stall_bad = 0;
    stall_left = 0; stall_beat = -1; wait_mode = 0; prev_low = 1'b0; cons = 1'b0;
    wbase = base; wr_data = base; wr_valid = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    cmd_valid = 1'b0;
    if (cons) begin
      widx++;
      wr_data = wbase + 16'(widx);
    end
    if (wr_ready && widx == stall_beat && stall_left > 0) begin
      wr_valid = 1'b0;
      stall_left--;
      nstall++;
      if (!EM_NWE || EM_D_oe) stall_bad++;
    end else wr_valid = 1'b1;
    low = !EM_NWE || !EM_NOE;
    if (low && !prev_low) begin
      if (npulse < 16) begin
        paddr[npulse] = EM_A; pdata[npulse] = EM_D_o; pncs[npulse] = EM_NCS;
        pstart[npulse] = cyc; plen[npulse] = 0;
      end
      npulse++;
    end
    if (low && npulse <= 16) plen[npulse-1]++;
    EM_WAIT0 = wait_mode == 1 || (wait_mode == 2 && low && npulse <= 16 && plen[npulse-1] >= 4 && plen[npulse-1] <= 6);
    prev_low = low;
    if (rd_valid) begin
      if (nrd < 16) rdv[nrd] = rd_data;
      nrd++;
      last_rd = cyc;
    end
    if (busy) busy_cyc++;
    cons = wr_ready && wr_valid;
  endtask

  task automatic send_cmd(input logic w, input logic [0:0] cs, input logic [9:0] addr, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_write = w; cmd_cs = cs; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < maxc);
    nvec++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL run_idle: busy=%b cmd_ready=%b required 0/1 after %0d cycles", busy, cmd_ready, n);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) begin
      @(negedge clk);
      nvec++;
      if ({EM_NCS, EM_NWE, EM_NOE, EM_D_oe, busy, cmd_ready} !== 7'b11_11_000) begin
        nfail++;
        $display("FAIL reset_pins: ncs/nwe/noe/oe/busy/rdy=%b required 1111000", {EM_NCS, EM_NWE, EM_NOE, EM_D_oe, busy, cmd_ready});
      end
    end
    nvec++;
    if ({EM_A, EM_D_o, wr_ready, rd_valid, timeout_err} !== 29'h0) begin
      nfail++;
      $display("FAIL reset_vals: A=%h D_o=%h wr_ready=%b rd_valid=%b tmo=%b required all 0", EM_A, EM_D_o, wr_ready, rd_valid, timeout_err);
    end
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL post_reset_ready: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_burst();
    clr(16'hA000);
    send_cmd(1'b1, 1'b1, 10'h010, 8'd3);
    run_idle(100);
    nvec++;
    if (npulse != 4 || busy_cyc != 32) begin
      nfail++;
      $display("FAIL wr_counts: pulses=%0d busy=%0d required 4/32", npulse, busy_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (plen[i] != 4 || paddr[i] !== 10'h010 + 10'(i) || pdata[i] !== 16'hA000 + 16'(i) || pncs[i] !== 2'b01) begin
        nfail++;
        $display("FAIL wr_beat%0d: len=%0d A=%h D=%h ncs=%b required 4/%h/%h/01", i, plen[i], paddr[i], pdata[i], pncs[i], 10'h010 + 10'(i), 16'hA000 + 16'(i));
      end
    end
    nvec++;
    if (pstart[1] - pstart[0] != 8 || pstart[3] - pstart[2] != 8) begin
      nfail++;
      $display("FAIL wr_period: %0d/%0d required 8/8", pstart[1] - pstart[0], pstart[3] - pstart[2]);
    end
  endtask

  task automatic test_read_wrap();
    logic [15:0] exp [3];
    exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
    clr(16'h0000);
    send_cmd(1'b0, 1'b0, 10'h3FE, 8'd2);
    run_idle(100);
    nvec++;
    if (npulse != 3 || nrd != 3 || busy_cyc != 23 || cyc - last_rd != 3) begin
      nfail++;
      $display("FAIL rd_counts: pulses=%0d rd=%0d busy=%0d turn_gap=%0d required 3/3/23/3", npulse, nrd, busy_cyc, cyc - last_rd);
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (rdv[i] !== exp[i] || plen[i] != 4 || pncs[i] !== 2'b10) begin
        nfail++;
        $display("FAIL rd_beat%0d: data=%h len=%0d ncs=%b required %h/4/10", i, rdv[i], plen[i], pncs[i], exp[i]);
      end
    end
    nvec++;
    if (paddr[1] !== 10'h3FF || paddr[2] !== 10'h000 || pstart[1] - pstart[0] != 7) begin
      nfail++;
      $display("FAIL rd_wrap: A1=%h A2=%h period=%0d required 3ff/000/7", paddr[1], paddr[2], pstart[1] - pstart[0]);
    end
  endtask

  task automatic test_wdata_stall();
    clr(16'h5A00);
    stall_beat = 1; stall_left = 5;
    send_cmd(1'b1, 1'b0, 10'h040, 8'd1);
    run_idle(100);
    nvec++;
    if (nstall != 5 || stall_bad != 0 || busy_cyc != 21) begin
      nfail++;
      $display("FAIL wr_stall: stall=%0d bad=%0d busy=%0d required 5/0/21", nstall, stall_bad, busy_cyc);
    end
    nvec++;
    if (npulse != 2 || pdata[1] !== 16'h5A01 || paddr[1] !== 10'h041 || pstart[1] - pstart[0] != 13) begin
      nfail++;
      $display("FAIL wr_stall_beat: pulses=%0d D=%h A=%h period=%0d required 2/5a01/041/13", npulse, pdata[1], paddr[1], pstart[1] - pstart[0]);
    end
  endtask

  task automatic test_long_burst();
    clr(16'h0000);
    send_cmd(1'b0, 1'b0, 10'h3F0, 8'd255);
    run_idle(3000);
    nvec++;
    if (npulse != 256 || nrd != 256 || busy_cyc != 1794) begin
      nfail++;
      $display("FAIL long_burst: pulses=%0d rd=%0d busy=%0d required 256/256/1794", npulse, nrd, busy_cyc);
    end
    nvec++;
    if (rdv[15] !== mem[10'h3FF] || EM_A !== 10'h0EF) begin
      nfail++;
      $display("FAIL long_burst_addr: rd15=%h A=%h required %h/0ef", rdv[15], EM_A, mem[10'h3FF]);
    end
  endtask

  task automatic test_wait();
`ifdef GPMC_WAIT_EN
    clr(16'h0000);
    wait_mode = 2;
    send_cmd(1'b0, 1'b0, 10'h020, 8'd0);
    run_idle(100);
    nvec++;
    if (plen[0] != 7 || timeout_err !== 1'b0 || nrd != 1 || rdv[0] !== mem[10'h020]) begin
      nfail++;
      $display("FAIL wait_3: noe_len=%0d tmo=%b rd=%0d data=%h required 7/0/1/%h", plen[0], timeout_err, nrd, rdv[0], mem[10'h020]);
    end
    clr(16'h0000);
    wait_mode = 1;
    send_cmd(1'b0, 1'b0, 10'h021, 8'd0);
    run_idle(100);
    wait_mode = 0;
    EM_WAIT0 = 1'b0;
    nvec++;
    if (plen[0] != 12 || timeout_err !== 1'b1 || nrd != 1 || rdv[0] !== mem[10'h021]) begin
      nfail++;
      $display("FAIL wait_timeout: noe_len=%0d tmo=%b rd=%0d data=%h required 12/1/1/%h", plen[0], timeout_err, nrd, rdv[0], mem[10'h021]);
    end
    reset_dut();
    nvec++;
    if (timeout_err !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_clear: tmo=%b required 0", timeout_err);
    end
`else
    clr(16'h0000);
    wait_mode = 1;
    send_cmd(1'b0, 1'b0, 10'h020, 8'd0);
    run_idle(100);
    wait_mode = 0;
    EM_WAIT0 = 1'b0;
    nvec++;
    if (plen[0] != 4 || timeout_err !== 1'b0 || nrd != 1 || rdv[0] !== mem[10'h020]) begin
      nfail++;
      $display("FAIL wait_ignored: noe_len=%0d tmo=%b rd=%0d data=%h required 4/0/1/%h", plen[0], timeout_err, nrd, rdv[0], mem[10'h020]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0, bad = 0;
    clr(16'hC000);
    send_cmd(1'b1, 1'b1, 10'h100, 8'd3);
    do begin
      cycle();
      n++;
    end while (!(npulse == 1 && plen[0] == 2) && n < 40);
    nvec++;
    if (npulse != 1 || plen[0] != 2 || EM_NWE !== 1'b0) begin
      nfail++;
      $display("FAIL mid_reach: pulses=%0d len=%0d nwe=%b required 1/2/0", npulse, plen[0], EM_NWE);
    end
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if ({EM_NWE, EM_NOE, EM_NCS, EM_D_oe, busy} !== 6'b1111_00) begin
      nfail++;
      $display("FAIL mid_reset: nwe/noe/ncs/oe/busy=%b required 111100", {EM_NWE, EM_NOE, EM_NCS, EM_D_oe, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rd_valid || wr_ready || busy) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL mid_quiet: %0d cycles with rd_valid/wr_ready/busy, required 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 16'h0100);
    mem[10'h3FE] = 16'h1111;
    mem[10'h3FF] = 16'h2222;
    mem[10'h000] = 16'h3333;
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_wdata_stall();
    test_long_burst();
    test_wait();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
